// File: rtl/hazard_ctrl.sv
// hazard_ctrl: backward-path pipeline control -- operand forwarding into ID, multi-cycle
// load-use stall and taken-branch flush. Define HAZARD_PERF_EN for stall/flush cycle counters.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rR1_i,
    input  logic [4:0]  id_rR2_i,
    input  logic        id_re1_i,
    input  logic        id_re2_i,
    input  logic [31:0] id_rD1_i,
    input  logic [31:0] id_rD2_i,
    input  logic [4:0]  ex_wR_i,
    input  logic        ex_rf_we_i,
    input  logic [1:0]  ex_rf_wsel_i,
    input  logic [31:0] ex_wD_i,
    input  logic [4:0]  mem_wR_i,
    input  logic        mem_rf_we_i,
    input  logic [31:0] mem_wD_i,
    input  logic [4:0]  wb_wR_i,
    input  logic        wb_rf_we_i,
    input  logic [31:0] wb_wD_i,
    input  logic        ex_br_taken_i,
    output logic [31:0] fwd_rD1_o,
    output logic [31:0] fwd_rD2_o,
    output logic        pc_stall_o,
    output logic        ifid_stall_o,
    output logic        ifid_flush_o,
    output logic        idex_flush_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);

    localparam logic [1:0] WselRam   = 2'd1;
    localparam logic [2:0] StallInit = 3'(LOAD_STALL - 1);

    if (LOAD_STALL < 1 || LOAD_STALL > 7) begin : g_param_check
        $error("hazard_ctrl: LOAD_STALL must be within 1..7");
    end

    typedef enum logic [0:0] {
        StIdle,
        StStall
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic ex_fwd_ok;
    logic ex_hit1, mem_hit1, wb_hit1;
    logic ex_hit2, mem_hit2, wb_hit2;
    logic rd1_live, rd2_live;
    logic load_use;
    logic stall;
    logic br_flush;

    // A load's data is not available in EX; it falls through to the MEM/WB sources instead.
    assign ex_fwd_ok = ex_rf_we_i && (ex_rf_wsel_i != WselRam);

    assign rd1_live = id_re1_i && (id_rR1_i != 5'd0);
    assign rd2_live = id_re2_i && (id_rR2_i != 5'd0);

    assign ex_hit1  = rd1_live && ex_fwd_ok   && (ex_wR_i  == id_rR1_i);
    assign mem_hit1 = rd1_live && mem_rf_we_i && (mem_wR_i == id_rR1_i);
    assign wb_hit1  = rd1_live && wb_rf_we_i  && (wb_wR_i  == id_rR1_i);

    assign ex_hit2  = rd2_live && ex_fwd_ok   && (ex_wR_i  == id_rR2_i);
    assign mem_hit2 = rd2_live && mem_rf_we_i && (mem_wR_i == id_rR2_i);
    assign wb_hit2  = rd2_live && wb_rf_we_i  && (wb_wR_i  == id_rR2_i);

    always_comb begin
        fwd_rD1_o = id_rD1_i;
        if (ex_hit1) begin
            fwd_rD1_o = ex_wD_i;
        end else if (mem_hit1) begin
            fwd_rD1_o = mem_wD_i;
        end else if (wb_hit1) begin
            fwd_rD1_o = wb_wD_i;
        end
    end

    always_comb begin
        fwd_rD2_o = id_rD2_i;
        if (ex_hit2) begin
            fwd_rD2_o = ex_wD_i;
        end else if (mem_hit2) begin
            fwd_rD2_o = mem_wD_i;
        end else if (wb_hit2) begin
            fwd_rD2_o = wb_wD_i;
        end
    end

    assign load_use = ex_rf_we_i && (ex_rf_wsel_i == WselRam) && (ex_wR_i != 5'd0) &&
                      ((id_re1_i && (id_rR1_i == ex_wR_i)) ||
                       (id_re2_i && (id_rR2_i == ex_wR_i)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A taken branch squashes the stalled instruction, so it overrides and aborts any stall.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        br_flush = 1'b0;
        if (ex_br_taken_i) begin
            br_flush = 1'b1;
            state_d  = StIdle;
            cnt_d    = 3'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load_use) begin
                        stall = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_d = StStall;
                            cnt_d   = StallInit;
                        end
                    end
                end
                StStall: begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = StIdle;
                    end
                end
            endcase
        end
    end

    assign pc_stall_o   = stall;
    assign ifid_stall_o = stall;
    assign ifid_flush_o = br_flush;
    assign idex_flush_o = stall | br_flush;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_q + 32'(stall);
            perf_flush_q <= perf_flush_q + 32'(br_flush);
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`else
    // Counters compiled out; stall and flush behaviour is unchanged.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (LOAD_STALL=1 and 3) share stimulus and
// are compared each cycle against a remaining-stall-cycles reference model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  id_rR1, id_rR2, ex_wR, mem_wR, wb_wR;
    logic        id_re1, id_re2, ex_rf_we, mem_rf_we, wb_rf_we, ex_br_taken;
    logic [1:0]  ex_rf_wsel;
    logic [31:0] id_rD1, id_rD2, ex_wD, mem_wD, wb_wD;

    logic [31:0] f1_a, f2_a, f1_b, f2_b;
    logic        pcs_a, ifs_a, iff_a, idf_a;
    logic        pcs_b, ifs_b, iff_b, idf_b;
    logic [3:0]  ctl_a, ctl_b;
    assign ctl_a = {pcs_a, ifs_a, iff_a, idf_a};
    assign ctl_b = {pcs_b, ifs_b, iff_b, idf_b};

`ifdef HAZARD_PERF_EN
    logic [31:0] ps_a, pf_a, ps_b, pf_b;
    logic [31:0] mps_a, mpf_a, mps_b, mpf_b;
`endif

    hazard_ctrl #(.LOAD_STALL(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .id_rR1_i(id_rR1), .id_rR2_i(id_rR2), .id_re1_i(id_re1), .id_re2_i(id_re2),
        .id_rD1_i(id_rD1), .id_rD2_i(id_rD2),
        .ex_wR_i(ex_wR), .ex_rf_we_i(ex_rf_we), .ex_rf_wsel_i(ex_rf_wsel), .ex_wD_i(ex_wD),
        .mem_wR_i(mem_wR), .mem_rf_we_i(mem_rf_we), .mem_wD_i(mem_wD),
        .wb_wR_i(wb_wR), .wb_rf_we_i(wb_rf_we), .wb_wD_i(wb_wD),
        .ex_br_taken_i(ex_br_taken),
        .fwd_rD1_o(f1_a), .fwd_rD2_o(f2_a),
        .pc_stall_o(pcs_a), .ifid_stall_o(ifs_a), .ifid_flush_o(iff_a), .idex_flush_o(idf_a)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt_o(ps_a), .perf_flush_cnt_o(pf_a)
`endif
    );

    hazard_ctrl #(.LOAD_STALL(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .id_rR1_i(id_rR1), .id_rR2_i(id_rR2), .id_re1_i(id_re1), .id_re2_i(id_re2),
        .id_rD1_i(id_rD1), .id_rD2_i(id_rD2),
        .ex_wR_i(ex_wR), .ex_rf_we_i(ex_rf_we), .ex_rf_wsel_i(ex_rf_wsel), .ex_wD_i(ex_wD),
        .mem_wR_i(mem_wR), .mem_rf_we_i(mem_rf_we), .mem_wD_i(mem_wD),
        .wb_wR_i(wb_wR), .wb_rf_we_i(wb_rf_we), .wb_wD_i(wb_wD),
        .ex_br_taken_i(ex_br_taken),
        .fwd_rD1_o(f1_b), .fwd_rD2_o(f2_b),
        .pc_stall_o(pcs_b), .ifid_stall_o(ifs_b), .ifid_flush_o(iff_b), .idex_flush_o(idf_b)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt_o(ps_b), .perf_flush_cnt_o(pf_b)
`endif
    );

    int unsigned checks = 0;
    int unsigned failures = 0;
    int rem_a = 0;
    int rem_b = 0;

    // Reference model: stall cycles still owed per instance, plus spec-level rules.
    function automatic logic hazard();
        return ex_rf_we && (ex_rf_wsel == 2'd1) && (ex_wR != 5'd0) &&
               ((id_re1 && (id_rR1 == ex_wR)) || (id_re2 && (id_rR2 == ex_wR)));
    endfunction

    function automatic logic [31:0] exp_fwd(input logic [4:0] rr, input logic re,
                                            input logic [31:0] rd);
        logic [4:0]  wr[3];
        logic        we[3];
        logic [31:0] wd[3];
        wr = '{ex_wR, mem_wR, wb_wR};
        we = '{ex_rf_we && (ex_rf_wsel != 2'd1), mem_rf_we, wb_rf_we};
        wd = '{ex_wD, mem_wD, wb_wD};
        if (!re || rr == 5'd0) return rd;
        for (int i = 0; i < 3; i++) begin
            if (we[i] && wr[i] == rr) return wd[i];
        end
        return rd;
    endfunction

    // {pc_stall, ifid_stall, ifid_flush, idex_flush}
    function automatic logic [3:0] exp_ctl(input int rem);
        if (ex_br_taken) return 4'b0011;
        if (rem > 0 || hazard()) return 4'b1101;
        return 4'b0000;
    endfunction

    function automatic int next_rem(input int rem, input int n);
        if (ex_br_taken) return 0;
        if (rem > 0) return rem - 1;
        if (hazard()) return n - 1;
        return 0;
    endfunction

    task automatic tick();
        logic [3:0] ea, eb;
        @(posedge clk);
        ea = exp_ctl(rem_a);
        eb = exp_ctl(rem_b);
`ifdef HAZARD_PERF_EN
        if (rst) begin
            mps_a = 0; mpf_a = 0; mps_b = 0; mpf_b = 0;
        end else begin
            mps_a = mps_a + 32'(ea[3]); mpf_a = mpf_a + 32'(ea[1]);
            mps_b = mps_b + 32'(eb[3]); mpf_b = mpf_b + 32'(eb[1]);
        end
`endif
        if (rst) begin
            rem_a = 0;
            rem_b = 0;
        end else begin
            rem_a = next_rem(rem_a, 1);
            rem_b = next_rem(rem_b, 3);
        end
        if (ea[3] && ea[1]) $display("model inconsistency %b", ea);
        if (eb[3] && eb[1]) $display("model inconsistency %b", eb);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0;
        id_rR1 = '0; id_rR2 = '0; id_re1 = 1'b0; id_re2 = 1'b0;
        id_rD1 = 32'hD1D1_0001; id_rD2 = 32'hD2D2_0002;
        ex_wR = '0; ex_rf_we = 1'b0; ex_rf_wsel = 2'd0; ex_wD = 32'h0;
        mem_wR = '0; mem_rf_we = 1'b0; mem_wD = 32'h0;
        wb_wR = '0; wb_rf_we = 1'b0; wb_wD = 32'h0;
        ex_br_taken = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++;
            if ({ctl_a, ctl_b} !== 8'h00) begin
                failures++;
                $display("FAIL reset_ctl cyc=%0d got=%h want=00", i, {ctl_a, ctl_b});
            end
            checks++;
            if ({f1_a, f2_a, f1_b, f2_b} !== {id_rD1, id_rD2, id_rD1, id_rD2}) begin
                failures++;
                $display("FAIL reset_fwd cyc=%0d got=%h %h want=%h %h", i, f1_a, f2_a,
                         id_rD1, id_rD2);
            end
`ifdef HAZARD_PERF_EN
            checks++;
            if ({ps_a, pf_a, ps_b, pf_b} !== 128'h0) begin
                failures++;
                $display("FAIL reset_perf got=%0d %0d %0d %0d want=0", ps_a, pf_a, ps_b, pf_b);
            end
`endif
            tick();
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] w1, w2;
        for (int k = 0; k < 8; k++) begin
            clear_inputs();
            w1 = id_rD1;
            w2 = id_rD2;
            case (k)
                0: begin
                    ex_rf_we = 1; ex_wR = 5; ex_wD = 32'h11; id_rR1 = 5; id_re1 = 1;
                    w1 = 32'h11;
                end
                1, 2, 3, 4: begin
                    ex_rf_we = (k < 2); ex_wR = 7; ex_wD = 32'hA;
                    mem_rf_we = (k < 3); mem_wR = 7; mem_wD = 32'hB;
                    wb_rf_we = 1; wb_wR = 7; wb_wD = 32'hC;
                    id_rR2 = 7; id_re2 = (k < 4);
                    w2 = (k == 1) ? 32'hA : (k == 2) ? 32'hB : (k == 3) ? 32'hC : id_rD2;
                end
                5: begin
                    ex_rf_we = 1; ex_wR = 0; ex_wD = 32'hFF; mem_rf_we = 1; mem_wR = 0;
                    mem_wD = 32'hEE; id_rR1 = 0; id_re1 = 1;
                end
                6: begin
                    ex_rf_we = 1; ex_rf_wsel = 2; ex_wR = 7; ex_wD = 32'h44;
                    id_rR1 = 7; id_re1 = 1;
                    w1 = 32'h44;
                end
                default: begin
                    ex_rf_we = 1; ex_rf_wsel = 1; ex_wR = 7; ex_wD = 32'hBAD;
                    mem_rf_we = 1; mem_wR = 7; mem_wD = 32'hB; id_rR2 = 7; id_re2 = 1;
                    w2 = 32'hB;
                end
            endcase
            #3;
            checks++;
            if ({f1_a, f2_a, f1_b, f2_b} !== {w1, w2, w1, w2}) begin
                failures++;
                $display("FAIL fwd_case%0d got=%h %h want=%h %h", k, f1_a, f2_a, w1, w2);
            end
            checks++;
            if ({ctl_a, ctl_b} !== {exp_ctl(rem_a), exp_ctl(rem_b)}) begin
                failures++;
                $display("FAIL fwd_ctl case%0d got=%h want=%h", k, {ctl_a, ctl_b},
                         {exp_ctl(rem_a), exp_ctl(rem_b)});
            end
            tick();
        end
        clear_inputs();
        repeat (3) tick();
    endtask

    // Step kinds: 0 idle, 1 load-use on rR1, 2 load now in MEM, 3 branch, 4 reset,
    // 5 branch with load-use, 6 load-use on rR2.
    task automatic test_load_use();
        int seq[$];
        seq = '{0, 1, 2, 0, 0, 0, 1, 3, 0, 0, 1, 4, 0, 0, 5, 0, 0, 0, 6, 0, 0, 0,
                1, 1, 1, 1, 0, 0, 0, 5, 5, 0};
        foreach (seq[i]) begin
            clear_inputs();
            if (seq[i] == 1 || seq[i] == 5) begin
                ex_rf_we = 1; ex_rf_wsel = 1; ex_wR = 3; ex_wD = 32'hBAD0;
                id_rR1 = 3; id_re1 = 1;
            end
            if (seq[i] == 2) begin
                mem_rf_we = 1; mem_wR = 3; mem_wD = 32'h55; id_rR1 = 3; id_re1 = 1;
            end
            if (seq[i] == 3 || seq[i] == 5) ex_br_taken = 1;
            if (seq[i] == 4) rst = 1;
            if (seq[i] == 6) begin
                ex_rf_we = 1; ex_rf_wsel = 1; ex_wR = 9; id_rR2 = 9; id_re2 = 1;
                id_rR1 = 9; id_re1 = 0;
            end
            #3;
            checks++;
            if ({f1_a, f2_a, f1_b, f2_b} !== {exp_fwd(id_rR1, id_re1, id_rD1),
                                              exp_fwd(id_rR2, id_re2, id_rD2),
                                              exp_fwd(id_rR1, id_re1, id_rD1),
                                              exp_fwd(id_rR2, id_re2, id_rD2)}) begin
                failures++;
                $display("FAIL lu_fwd step=%0d got=%h %h want=%h %h", i, f1_a, f2_a,
                         exp_fwd(id_rR1, id_re1, id_rD1), exp_fwd(id_rR2, id_re2, id_rD2));
            end
            if (!rst) begin
                checks++;
                if ({ctl_a, ctl_b} !== {exp_ctl(rem_a), exp_ctl(rem_b)}) begin
                    failures++;
                    $display("FAIL lu_ctl step=%0d kind=%0d got=%h want=%h", i, seq[i],
                             {ctl_a, ctl_b}, {exp_ctl(rem_a), exp_ctl(rem_b)});
                end
            end
`ifdef HAZARD_PERF_EN
            checks++;
            if ({ps_a, pf_a, ps_b, pf_b} !== {mps_a, mpf_a, mps_b, mpf_b}) begin
                failures++;
                $display("FAIL lu_perf step=%0d got=%0d %0d %0d %0d want=%0d %0d %0d %0d", i,
                         ps_a, pf_a, ps_b, pf_b, mps_a, mpf_a, mps_b, mpf_b);
            end
`endif
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            id_rR1 = 5'($urandom_range(0, 3)); id_rR2 = 5'($urandom_range(0, 3));
            id_re1 = 1'($urandom); id_re2 = 1'($urandom);
            id_rD1 = $urandom; id_rD2 = $urandom;
            ex_wR = 5'($urandom_range(0, 3)); ex_rf_we = 1'($urandom);
            ex_rf_wsel = 2'($urandom); ex_wD = $urandom;
            mem_wR = 5'($urandom_range(0, 3)); mem_rf_we = 1'($urandom); mem_wD = $urandom;
            wb_wR = 5'($urandom_range(0, 3)); wb_rf_we = 1'($urandom); wb_wD = $urandom;
            ex_br_taken = ($urandom_range(0, 7) == 0);
            #3;
            checks++;
            if ({f1_a, f2_a, f1_b, f2_b} !== {exp_fwd(id_rR1, id_re1, id_rD1),
                                              exp_fwd(id_rR2, id_re2, id_rD2),
                                              exp_fwd(id_rR1, id_re1, id_rD1),
                                              exp_fwd(id_rR2, id_re2, id_rD2)}) begin
                failures++;
                $display("FAIL rnd_fwd cyc=%0d got=%h %h want=%h %h", i, f1_a, f2_a,
                         exp_fwd(id_rR1, id_re1, id_rD1), exp_fwd(id_rR2, id_re2, id_rD2));
            end
            if (!rst) begin
                checks++;
                if ({ctl_a, ctl_b} !== {exp_ctl(rem_a), exp_ctl(rem_b)}) begin
                    failures++;
                    $display("FAIL rnd_ctl cyc=%0d got=%h want=%h", i, {ctl_a, ctl_b},
                             {exp_ctl(rem_a), exp_ctl(rem_b)});
                end
            end
`ifdef HAZARD_PERF_EN
            checks++;
            if ({ps_a, pf_a, ps_b, pf_b} !== {mps_a, mpf_a, mps_b, mpf_b}) begin
                failures++;
                $display("FAIL rnd_perf cyc=%0d got=%0d %0d %0d %0d want=%0d %0d %0d %0d", i,
                         ps_a, pf_a, ps_b, pf_b, mps_a, mpf_a, mps_b, mpf_b);
            end
`endif
            tick();
        end
    endtask

    initial begin
`ifdef HAZARD_PERF_EN
        mps_a = 0; mpf_a = 0; mps_b = 0; mpf_b = 0;
`endif
        test_reset();
        test_forwarding();
        test_load_use();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
